systolic_pe_q88: RTL and testbench

- Weight-stationary multiply-accumulate processing element, one cell of the systolic-array matrix unit.
- Activations enter from the left and are forwarded right.
- Weights stream down the column into a shadow (inactive) register; a switch pulse promotes the shadow weight to the active weight.
- Each valid cycle computes psum_out = input × active_weight + psum_in in signed fixed point and passes the result down.

---
 rtl/systolic_pe_q88.sv | 141 ++++++++++++++
 tb/tb_systolic_pe_q88.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_pe_q88.sv
// systolic_pe_q88: one weight-stationary multiply-accumulate cell of a
// systolic-array matrix unit, signed fixed point (default Q8.8).
//   - Activations enter from the left and are forwarded right.
//   - Weights stream down the column into a shadow register. A switch pulse
//     promotes the shadow weight to the active weight.
//   - Each valid cycle produces psum_out = input * active_w + psum_in.
// Every output is registered, one cycle from input to output.
// Build option PE_SATURATE_EN: when defined, the product and the sum clamp to
// the signed range on overflow. When undefined, both wrap (two's complement).
// Inside the range both builds give identical results.
module systolic_pe_q88 #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pe_valid_in,
  input  logic              pe_accept_w_in,
  input  logic [DATA_W-1:0] pe_input_in,
  input  logic [DATA_W-1:0] pe_weight_in,
  input  logic [DATA_W-1:0] pe_psum_in,
  input  logic              pe_switch_in,
  output logic              pe_valid_out,
  output logic              pe_switch_out,
  output logic [DATA_W-1:0] pe_input_out,
  output logic [DATA_W-1:0] pe_weight_out,
  output logic [DATA_W-1:0] pe_psum_out
);

  localparam int PW = 2 * DATA_W;   // full product width
  localparam int SW = PW - FRAC_W;  // product width after dropping fraction bits
  localparam logic [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (FRAC_W - 1);

`ifdef PE_SATURATE_EN
  localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b0}}} | {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  logic prod_ovf;
  logic sum_ovf;
`endif

  // Architectural state
  logic              valid_q,  valid_d;
  logic              switch_q, switch_d;
  logic [DATA_W-1:0] input_q,  input_d;
  logic [DATA_W-1:0] weight_q, weight_d;
  logic [DATA_W-1:0] psum_q,   psum_d;
  logic [DATA_W-1:0] active_w_q, active_w_d;
  logic [DATA_W-1:0] shadow_w_q, shadow_w_d;

  // Datapath intermediates
  logic [PW-1:0]     prod;
  logic [PW-1:0]     prod_rnd;
  logic [SW-1:0]     prod_sh;
  logic [DATA_W-1:0] prod_red;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] sum_red;

  // Rounded product of the activation and the active weight, then add psum_in.
  always_comb begin
    // Size casts of signed operands sign-extend, giving the full signed product.
    prod     = PW'($signed(pe_input_in)) * PW'($signed(active_w_q));
    prod_rnd = prod + RND;
    // Dropping the low FRAC_W bits of the signed value is an arithmetic shift.
    prod_sh  = prod_rnd[PW-1:FRAC_W];
`ifdef PE_SATURATE_EN
    // Overflow when the bits above the result sign are not all copies of it.
    prod_ovf = !((&prod_sh[SW-1:DATA_W-1]) || !(|prod_sh[SW-1:DATA_W-1]));
    prod_red = prod_ovf ? (prod_sh[SW-1] ? S_MIN : S_MAX) : prod_sh[DATA_W-1:0];
`else
    prod_red = prod_sh[DATA_W-1:0];
`endif
    sum = {prod_red[DATA_W-1], prod_red} + {pe_psum_in[DATA_W-1], pe_psum_in};
`ifdef PE_SATURATE_EN
    sum_ovf = sum[DATA_W] != sum[DATA_W-1];
    sum_red = sum_ovf ? (sum[DATA_W] ? S_MIN : S_MAX) : sum[DATA_W-1:0];
`else
    sum_red = sum[DATA_W-1:0];
`endif
  end

  // Bits consumed only by the saturating build, or never needed at all.
  logic unused_bits;
  assign unused_bits = ^{prod_rnd[FRAC_W-1:0], prod_sh[SW-1:DATA_W], sum[DATA_W]};

  // Next-state selection for weights, forwarding registers and MAC result.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    valid_d    = pe_valid_in;
    switch_d   = pe_switch_in;
    input_d    = input_q;
    weight_d   = '0;
    psum_d     = '0;
    active_w_d = active_w_q;
    shadow_w_d = shadow_w_q;

    if (pe_accept_w_in) begin
      shadow_w_d = pe_weight_in;
      weight_d   = pe_weight_in;
    end
    // Promote the shadow value from before this edge. A weight accepted in
    // the same cycle lands in the shadow and waits for the next switch.
    if (pe_switch_in) begin
      active_w_d = shadow_w_q;
    end
    // The MAC reads active_w_q, so a switch in a valid cycle takes effect
    // from the following cycle.
    if (pe_valid_in) begin
      input_d = pe_input_in;
      psum_d  = sum_red;
    end
  end

  // State registers with synchronous active-high reset. Reset also discards loaded weights.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register take its value from before the edge.
    if (rst) begin
      valid_q    <= 1'b0;
      switch_q   <= 1'b0;
      input_q    <= '0;
      weight_q   <= '0;
      psum_q     <= '0;
      active_w_q <= '0;
      shadow_w_q <= '0;
    end else begin
      valid_q    <= valid_d;
      switch_q   <= switch_d;
      input_q    <= input_d;
      weight_q   <= weight_d;
      psum_q     <= psum_d;
      active_w_q <= active_w_d;
      shadow_w_q <= shadow_w_d;
    end
  end

  assign pe_valid_out  = valid_q;
  assign pe_switch_out = switch_q;
  assign pe_input_out  = input_q;
  assign pe_weight_out = weight_q;
  assign pe_psum_out   = psum_q;

endmodule

// File: tb/tb_systolic_pe_q88.sv
// Testbench for systolic_pe_q88 (Q8.8 defaults).
// Part 1 applies a table of directed vectors with hand-derived expectations.
// Part 2 applies randomized traffic checked against an integer reference model.
// When compiled with PE_SATURATE_EN the expectations switch to clamping.
module tb_systolic_pe_q88;

  logic        clk;
  logic        rst;
  logic        valid_i, accept_i, switch_i;
  logic [15:0] input_i, weight_i, psum_i;
  logic        valid_o, switch_o;
  logic [15:0] input_o, weight_o, psum_o;

  int n_checks = 0;
  int n_errors = 0;

  systolic_pe_q88 dut (
    .clk           (clk),
    .rst           (rst),
    .pe_valid_in   (valid_i),
    .pe_accept_w_in(accept_i),
    .pe_input_in   (input_i),
    .pe_weight_in  (weight_i),
    .pe_psum_in    (psum_i),
    .pe_switch_in  (switch_i),
    .pe_valid_out  (valid_o),
    .pe_switch_out (switch_o),
    .pe_input_out  (input_o),
    .pe_weight_out (weight_o),
    .pe_psum_out   (psum_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst, valid, acc, sw;
    logic [15:0] in, w, psum;
    logic        e_valid, e_sw;
    logic [15:0] e_in, e_w, e_psum;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic a, input logic s,
                       input logic [15:0] in, input logic [15:0] w, input logic [15:0] p);
    rst = r; valid_i = v; accept_i = a; switch_i = s;
    input_i = in; weight_i = w; psum_i = p;
  endtask

  task automatic check_all(input string tag, input logic ev, input logic es,
                           input logic [15:0] ein, input logic [15:0] ew, input logic [15:0] ep);
    check({tag, "_valid"},  {15'd0, valid_o},  {15'd0, ev});
    check({tag, "_switch"}, {15'd0, switch_o}, {15'd0, es});
    check({tag, "_input"},  input_o,  ein);
    check({tag, "_weight"}, weight_o, ew);
    check({tag, "_psum"},   psum_o,   ep);
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic a, input logic s,
                              input logic [15:0] in, input logic [15:0] w, input logic [15:0] p,
                              input logic ev, input logic es, input logic [15:0] ein,
                              input logic [15:0] ew, input logic [15:0] ep);
    vec_t t;
    t.rst = r; t.valid = v; t.acc = a; t.sw = s; t.in = in; t.w = w; t.psum = p;
    t.e_valid = ev; t.e_sw = es; t.e_in = ein; t.e_w = ew; t.e_psum = ep;
    return t;
  endfunction

  // ---- Reference model: plain integer arithmetic on real-number semantics ----
  logic [15:0] m_active, m_shadow, m_in;

  function automatic logic [15:0] reduce16(input longint x);
    logic [63:0] t;
`ifdef PE_SATURATE_EN
    if (x > 32767)  x = 32767;
    if (x < -32768) x = -32768;
`endif
    t = x;
    return t[15:0];
  endfunction

  function automatic logic [15:0] ref_mac(input logic [15:0] in, input logic [15:0] w,
                                          input logic [15:0] p);
    longint prod, scaled;
    prod   = longint'($signed(in)) * longint'($signed(w));
    scaled = (prod + 128) >>> 8;  // round half up, then scale by 2^-8
    return reduce16(longint'($signed(reduce16(scaled))) + longint'($signed(p)));
  endfunction

  function automatic logic [15:0] rnd16();
    if ($urandom_range(0, 1) == 1) return 16'($urandom());
    return 16'(int'($urandom_range(0, 1023)) - 512);
  endfunction

`ifdef PE_SATURATE_EN
  localparam logic [15:0] OVF_EXP = 16'h7FFF;
`else
  localparam logic [15:0] OVF_EXP = 16'h8A00;
`endif

  initial begin
    // Directed vectors: rst valid acc sw  in  w  psum  | valid sw in_o w_o psum_o
    vecs.push_back(mk(1,1,1,1, 16'h1234,16'h5678,16'h1111, 0,0,16'h0000,16'h0000,16'h0000)); // reset, inputs busy
    vecs.push_back(mk(0,1,0,0, 16'h0200,16'h0000,16'h1000, 1,0,16'h0200,16'h0000,16'h1000)); // active weight 0
    vecs.push_back(mk(0,0,1,0, 16'h0000,16'h4500,16'h0000, 0,0,16'h0200,16'h4500,16'h0000)); // load 69.0
    vecs.push_back(mk(0,0,1,0, 16'h0000,16'h0A00,16'h0000, 0,0,16'h0200,16'h0A00,16'h0000)); // load 10.0
    vecs.push_back(mk(0,0,0,0, 16'h0000,16'h0000,16'h0000, 0,0,16'h0200,16'h0000,16'h0000)); // accept drops
    vecs.push_back(mk(0,1,0,1, 16'h0200,16'h0000,16'h3200, 1,1,16'h0200,16'h0000,16'h3200)); // switch+valid: old weight
    vecs.push_back(mk(0,1,0,0, 16'h0200,16'h0000,16'h3200, 1,0,16'h0200,16'h0000,16'h4600)); // new weight 10.0
    vecs.push_back(mk(0,0,0,0, 16'h0700,16'h0000,16'h0000, 0,0,16'h0200,16'h0000,16'h0000)); // valid gating
    vecs.push_back(mk(0,0,1,0, 16'h0000,16'h4500,16'h0000, 0,0,16'h0200,16'h4500,16'h0000)); // load 69.0
    vecs.push_back(mk(0,0,0,1, 16'h0000,16'h0000,16'h0000, 0,1,16'h0200,16'h0000,16'h0000)); // promote
    vecs.push_back(mk(0,1,0,0, 16'h0200,16'h0000,16'h0000, 1,0,16'h0200,16'h0000,OVF_EXP));  // product overflow
    vecs.push_back(mk(0,1,1,1, 16'h0100,16'hFF80,16'h0000, 1,1,16'h0100,16'hFF80,16'h4500)); // accept+switch together
    vecs.push_back(mk(0,0,0,1, 16'h0000,16'h0000,16'h0000, 0,1,16'h0100,16'h0000,16'h0000)); // promote -0.5
    vecs.push_back(mk(0,1,0,0, 16'h0001,16'h0000,16'h0000, 1,0,16'h0001,16'h0000,16'h0000)); // -0.5 LSB rounds up
    vecs.push_back(mk(0,0,1,0, 16'h0000,16'hFE00,16'h0000, 0,0,16'h0001,16'hFE00,16'h0000)); // load -2.0
    vecs.push_back(mk(0,0,0,1, 16'h0000,16'h0000,16'h0000, 0,1,16'h0001,16'h0000,16'h0000)); // promote
    vecs.push_back(mk(0,1,0,0, 16'h0300,16'h0000,16'h0100, 1,0,16'h0300,16'h0000,16'hFB00)); // -2*3+1 = -5
    vecs.push_back(mk(1,1,1,1, 16'h5555,16'h3333,16'h2222, 0,0,16'h0000,16'h0000,16'h0000)); // mid-run reset
    vecs.push_back(mk(0,1,0,1, 16'h0100,16'h0000,16'h0100, 1,1,16'h0100,16'h0000,16'h0100)); // weights discarded
    vecs.push_back(mk(0,1,0,0, 16'h0100,16'h0000,16'h0100, 1,0,16'h0100,16'h0000,16'h0100)); // shadow cleared too

    drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].acc, vecs[i].sw,
            vecs[i].in, vecs[i].w, vecs[i].psum);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_sw,
                vecs[i].e_in, vecs[i].e_w, vecs[i].e_psum);
    end

    // Randomized traffic against the reference model, starting from reset.
    drive(1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    tick();
    m_active = '0; m_shadow = '0; m_in = '0;
    check_all("rand_reset", 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);

    for (int c = 0; c < 400; c++) begin
      logic r, v, a, s;
      logic [15:0] in, w, p, e_in, e_w, e_p;
      r  = ($urandom_range(0, 99) < 2);
      v  = ($urandom_range(0, 9) < 7);
      a  = ($urandom_range(0, 9) < 3);
      s  = ($urandom_range(0, 9) < 2);
      in = rnd16(); w = rnd16(); p = rnd16();
      drive(r, v, a, s, in, w, p);
      if (r) begin
        m_active = '0; m_shadow = '0; m_in = '0;
        tick();
        check_all($sformatf("rand%0d", c), 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      end else begin
        e_w  = a ? w : 16'h0;
        e_p  = v ? ref_mac(in, m_active, p) : 16'h0;
        e_in = v ? in : m_in;
        if (s) m_active = m_shadow;
        if (a) m_shadow = w;
        m_in = e_in;
        tick();
        check_all($sformatf("rand%0d", c), v, s, e_in, e_w, e_p);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
